conv_sequencer: RTL

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_pkg.sv | 8 +
 rtl/conv_pos_cnt.sv | 30 +++
 rtl/conv_sequencer.sv | 72 +++++++
 3 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM encoding and geometry defaults for the 3x3 convolution sequencer
package conv_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  localparam int IMG_W_DEF = 32;
  localparam int IMG_H_DEF = 32;
  localparam int ADDR_W_DEF = 11;
  localparam int N = IMG_W_DEF * IMG_H_DEF;
endpackage

// File: rtl/conv_pos_cnt.sv
// conv_pos_cnt: raster row/column position of the pixel being pushed
//   clk, reset (sync, active-low); clear: return to (0,0); advance: step one pixel
//   r, c: current position; last: position is the final pixel of the frame
module conv_pos_cnt
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] r,
  output logic [ADDR_W-1:0] c,
  output logic              last
);
  logic eol;
  assign eol = c == ADDR_W'(IMG_W - 1);
  assign last = eol && r == ADDR_W'(IMG_H - 1);
  always_ff @(posedge clk)
    if (!reset || clear) begin
      r <= '0;
      c <= '0;
    end else if (advance) begin
      c <= eol ? '0 : c + ADDR_W'(1);
      r <= last ? '0 : eol ? r + ADDR_W'(1) : r;
    end
endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer: raster-scan pixel fetch and 3x3 window handshake for a line-buffered convolution
//   clk, reset (sync, active-low), start, abort, out_ready: control inputs
//   rd_addr/push/buf_clr: pixel-store read and line-buffer control
//   win_valid/out_row/out_col: window handshake and centre; busy, done: frame status
//   stall_cnt: stalled-window cycle counter, only with CONV_SEQ_PERF_EN defined
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              push,
  output logic              buf_clr,
  output logic              win_valid,
  output logic [ADDR_W-1:0] out_row,
  output logic [ADDR_W-1:0] out_col,
  output logic              busy,
  output logic              done
`ifdef CONV_SEQ_PERF_EN
  ,output logic [15:0]      stall_cnt
`endif
);
  state_t state, nxt;
  logic [ADDR_W-1:0] r, c;
  logic last, hit;
  assign buf_clr = reset && state == IDLE && start && !abort;
  // a held window blocks every push, so no pixel can overwrite the stalled buffers
  assign push = state == RUN && (!win_valid || out_ready);
  assign hit = push && r >= ADDR_W'(2) && c >= ADDR_W'(2);
  always_comb
    nxt = state == IDLE ? (start && !abort ? RUN : IDLE)
        : state == DONE || abort ? IDLE
        : state == RUN ? (push && last ? FLUSH : RUN)
        : (win_valid && out_ready ? DONE : FLUSH);
  conv_pos_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_pos (
    .clk(clk), .reset(reset), .clear(buf_clr), .advance(push), .r(r), .c(c), .last(last)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      rd_addr <= '0;
      win_valid <= 1'b0;
      out_row <= '0;
      out_col <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      busy <= nxt == RUN || nxt == FLUSH;
      done <= nxt == DONE;
      rd_addr <= buf_clr ? '0 : push ? rd_addr + ADDR_W'(1) : rd_addr;
      win_valid <= !abort && (hit || (win_valid && !out_ready));
      if (hit) begin
        out_row <= r - ADDR_W'(1);
        out_col <= c - ADDR_W'(1);
      end
    end
`ifdef CONV_SEQ_PERF_EN
  always_ff @(posedge clk)
    if (!reset || buf_clr)
      stall_cnt <= '0;
    else if (win_valid && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule
